// File: rtl/bus_demux_if.sv
// Bundle of the source handshake and both destination handshakes of bus_demux.
// The slave modport is the demux side; the master modport is the surrounding logic.
interface bus_demux_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    modport master (
        output in_data,
        output in_select,
        output in_valid,
        input  in_ready,
        input  out0_data,
        input  out0_valid,
        output out0_ready,
        input  out1_data,
        input  out1_valid,
        output out1_ready
    );

    modport slave (
        input  in_data,
        input  in_select,
        input  in_valid,
        output in_ready,
        output out0_data,
        output out0_valid,
        input  out0_ready,
        output out1_data,
        output out1_valid,
        input  out1_ready
    );
endinterface

// File: rtl/bus_demux.sv
// One-to-two demultiplexer with an independent one-entry slot per destination.
// Define BUS_DEMUX_STATS_EN to add per-destination transfer counters count0/count1.
module bus_demux #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_demux_if.slave  bus
`ifdef BUS_DEMUX_STATS_EN
    ,
    output logic [15:0] count0,
    output logic [15:0] count1
`endif
);

    typedef enum logic {
        StEmpty,
        StFull
    } slot_state_e;

    slot_state_e      slot0_q, slot0_d;
    slot_state_e      slot1_q, slot1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;

    logic ready0;
    logic ready1;
    logic in_ready;
    logic in_fire;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // A slot can take a new word if empty or if its current word leaves this same edge.
    always_comb begin
        ready0   = (slot0_q == StEmpty) || bus.out0_ready;
        ready1   = (slot1_q == StEmpty) || bus.out1_ready;
        in_ready = bus.in_select ? ready1 : ready0;
        in_fire  = bus.in_valid && in_ready;
        load0    = in_fire && !bus.in_select;
        load1    = in_fire && bus.in_select;
        drain0   = (slot0_q == StFull) && bus.out0_ready;
        drain1   = (slot1_q == StFull) && bus.out1_ready;
    end

    always_comb begin
        slot0_d = slot0_q;
        data0_d = data0_q;
        case (slot0_q)
            StEmpty: begin
                if (load0) begin
                    slot0_d = StFull;
                    data0_d = bus.in_data;
                end
            end
            StFull: begin
                if (load0) begin
                    data0_d = bus.in_data;
                end else if (drain0) begin
                    slot0_d = StEmpty;
                end
            end
            default: slot0_d = StEmpty;
        endcase
    end

    always_comb begin
        slot1_d = slot1_q;
        data1_d = data1_q;
        case (slot1_q)
            StEmpty: begin
                if (load1) begin
                    slot1_d = StFull;
                    data1_d = bus.in_data;
                end
            end
            StFull: begin
                if (load1) begin
                    data1_d = bus.in_data;
                end else if (drain1) begin
                    slot1_d = StEmpty;
                end
            end
            default: slot1_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= StEmpty;
            slot1_q <= StEmpty;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = (slot0_q == StFull);
    assign bus.out1_valid = (slot1_q == StFull);
    assign bus.out0_data  = data0_q;
    assign bus.out1_data  = data1_q;

`ifdef BUS_DEMUX_STATS_EN
    logic [15:0] count0_q, count0_d;
    logic [15:0] count1_q, count1_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (load0) begin
            count0_d = count0_q + 16'd1;
        end
        if (load1) begin
            count1_d = count1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign count0 = count0_q;
    assign count1 = count1_q;
`endif

endmodule

// File: tb/tb_bus_demux.sv
// Randomised and directed bench for bus_demux against a per-destination queue model.
// Define BUS_DEMUX_STATS_EN to also exercise the counters and their wrap.
module tb_bus_demux;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_demux_if #(.WIDTH(WIDTH)) bus ();

`ifdef BUS_DEMUX_STATS_EN
    logic [15:0] count0;
    logic [15:0] count1;
`endif

    bus_demux #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BUS_DEMUX_STATS_EN
        ,
        .count0(count0),
        .count1(count1)
`endif
    );

    // Reference: each destination is a queue of accepted-but-undelivered words (capacity 1).
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int unsigned      cnt0;
    int unsigned      cnt1;
    int               checks;
    int               failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven; check at the falling edge, then advance the model at the edge.
    task automatic tick();
        bit               exp_rdy;
        bit               t_in;
        bit               t0;
        bit               t1;
        bit               sel;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        if (bus.in_select) exp_rdy = (q1.size() == 0) || bus.out1_ready;
        else               exp_rdy = (q0.size() == 0) || bus.out0_ready;
        check("in_ready", bus.in_ready, exp_rdy);
        check("out0_valid", bus.out0_valid, q0.size() != 0);
        check("out1_valid", bus.out1_valid, q1.size() != 0);
        if (q0.size() != 0) check("out0_data", bus.out0_data, q0[0]);
        if (q1.size() != 0) check("out1_data", bus.out1_data, q1[0]);
`ifdef BUS_DEMUX_STATS_EN
        check("count0", count0, cnt0 % 65536);
        check("count1", count1, cnt1 % 65536);
`endif
        t0  = (q0.size() != 0) && bus.out0_ready;
        t1  = (q1.size() != 0) && bus.out1_ready;
        t_in = bus.in_valid && exp_rdy;
        sel = bus.in_select;
        w   = bus.in_data;
        @(posedge clk);
        if (t0) void'(q0.pop_front());
        if (t1) void'(q1.pop_front());
        if (t_in) begin
            if (sel) begin
                q1.push_back(w);
                cnt1++;
            end else begin
                q0.push_back(w);
                cnt0++;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                         input bit r0, input bit r1);
        bus.in_valid   = v;
        bus.in_select  = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    // Asserts reset off-edge, checks the immediate effect, then releases it.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out0_valid", bus.out0_valid, 0);
        check("rst_out1_valid", bus.out1_valid, 0);
        check("rst_out0_data", bus.out0_data, 0);
        check("rst_out1_data", bus.out1_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
`ifdef BUS_DEMUX_STATS_EN
        check("rst_count0", count0, 0);
        check("rst_count1", count1, 0);
`endif
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cnt0     = 0;
        cnt1     = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check("por_out0_valid", bus.out0_valid, 0);
        check("por_out1_valid", bus.out1_valid, 0);
        check("por_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill both slots, then reset asynchronously while both are full.
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        check("both_full0", bus.out0_valid, 1);
        check("both_full1", bus.out1_valid, 1);
        do_reset();

        // Basic steer to out1.
        drive(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("steer_v1", bus.out1_valid, 1);
        check("steer_d1", bus.out1_data, 16'h0001);
        check("steer_v0", bus.out0_valid, 0);
        tick();
        do_reset();

        // Stalled out0 must not block out1.
        drive(1'b1, 1'b0, 16'h0055, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0);
        #1;
        check("indep_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("indep_d1", bus.out1_data, 16'h00AA);
        check("indep_d0", bus.out0_data, 16'h0055);
        tick();
        do_reset();

        // Backpressure on out0, then re-steer the pending word to out1.
        drive(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_select = 1'b1;
        #1;
        check("resteer_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("resteer_v1", bus.out1_valid, 1);
        check("resteer_d1", bus.out1_data, 16'h0022);
        check("resteer_d0", bus.out0_data, 16'h0011);
        tick();
        do_reset();

        // Streaming through out0 with no bubble.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0);
            #1;
            check("stream_in_ready", bus.in_ready, 1);
            if (i > 0) begin
                check("stream_v0", bus.out0_valid, 1);
                check("stream_d0", bus.out0_data, i - 1);
            end
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("stream_last", bus.out0_data, 16'h0007);
        tick();
        tick();
        do_reset();

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), WIDTH'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        tick();

`ifdef BUS_DEMUX_STATS_EN
        do_reset();
        drive(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("wrap_count0", count0, 16'h0000);
        check("wrap_count1", count1, 16'h0001);
        tick();
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("post_wrap_count0", count0, 16'h0001);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_demux.md
BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH, the source word.
REQ-005 The block SHALL have port in_select, input, 1, the destination for the source word: 0 = out0, 1 = out1.
REQ-006 The block SHALL have port in_valid, input, 1, which marks in_data/in_select as valid.
REQ-007 The block SHALL have port in_ready, output, 1, which indicates the block accepts the source word this cycle.
REQ-008 The block SHALL have ports out0_data and out1_data, output, WIDTH, the held word for each destination.
REQ-009 The block SHALL have ports out0_valid and out1_valid, output, 1, which indicate the destination slot holds a word.
REQ-010 The block SHALL have ports out0_ready and out1_ready, input, 1, which indicate the destination consumes the held word.

Function
REQ-011 Each destination SHALL have a one-entry slot with states EMPTY and FULL; outN_valid SHALL be 1 exactly when slot N is FULL.
REQ-012 A transfer on the input SHALL occur on a rising clk edge when in_valid=1 and in_ready=1.
REQ-013 A transfer on output N SHALL occur on a rising clk edge when outN_valid=1 and outN_ready=1.
REQ-014 in_ready SHALL be combinational and equal to (slot S EMPTY) OR (outS_ready=1), where S=in_select; it SHALL NOT depend on the other slot.
REQ-015 On an input transfer, in_data SHALL be loaded into slot S, and slot S SHALL be FULL in the next cycle; the latency from accept to outS_valid is 1 cycle.
REQ-016 in_select SHALL be sampled only at the input transfer edge; changes to it while in_valid=1 and in_ready=0 SHALL be permitted and SHALL re-steer the pending word.
REQ-017 On an output transfer with no input transfer into the same slot, that slot SHALL go EMPTY.
REQ-018 When an output N transfer and an input transfer into slot N occur on the same edge, slot N SHALL stay FULL holding the new word, with no bubble and no loss.
REQ-019 The two slots SHALL operate independently; a stalled out0 SHALL NOT block input transfers to out1, and vice versa.
REQ-020 outN_data SHALL remain stable while outN_valid=1 and outN_ready=0.
REQ-021 outN_data SHALL hold its last value after a drain; downstream SHALL treat it as don't-care while outN_valid=0.
REQ-022 Words SHALL be delivered per destination in acceptance order, with no duplication and no drop.

Reset
REQ-023 While rst_n=0, both slots SHALL be EMPTY, out0_valid=out1_valid=0, out0_data=out1_data=0, and all counters SHALL be 0, independent of clk.
REQ-024 An assertion of rst_n mid-operation SHALL discard held words; in_ready SHALL follow REQ-014 with both slots EMPTY, i.e. it SHALL be 1.
REQ-025 Deassertion of rst_n SHALL take effect at the first rising clk edge after release.

Configuration
REQ-026 When BUS_DEMUX_STATS_EN is defined, the block SHALL add output ports count0 and count1, each 16 bits, holding the number of input transfers steered to out0 and out1 respectively, incrementing the cycle after each transfer and wrapping from 16'hFFFF to 16'h0000.
REQ-027 When BUS_DEMUX_STATS_EN is not defined, the ports count0/count1 and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Reset check: rst_n=0 asynchronously mid-cycle with both slots FULL -> out0_valid=out1_valid=0, data=16'h0000 immediately; in_ready=1.
REQ-029 Basic steer: in_data=16'h0001, in_select=1, in_valid=1 for one cycle, out1_ready=0 -> next cycle out1_valid=1, out1_data=16'h0001, out0_valid=0.
REQ-030 Independent stall: out0 FULL with out0_ready=0, then send 16'h00AA with select=1 -> in_ready=1, accepted; out1_data=16'h00AA; out0 word unchanged.
REQ-031 Backpressure: out0 FULL, out0_ready=0, in_select=0, in_valid=1 -> in_ready=0 for 5 cycles; in_select changed to 1 -> accepted on the next edge into out1.
REQ-032 Streaming: out0_ready=1 constantly, 8 back-to-back words 16'h0000..16'h0007 with select=0 -> in_ready=1 every cycle, out0 delivers all 8 in order with no bubble.
REQ-033 Stats (BUS_DEMUX_STATS_EN defined): preset 16'hFFFF transfers to out0 plus 1 more -> count0=16'h0000, count1 unchanged.
